// File: rtl/block_allocator_pkg.sv
// Shared encodings and size helpers for the next-fit block allocator.
package block_alloc_pkg;

    localparam logic [1:0] OP_ALLOC  = 2'd0;
    localparam logic [1:0] OP_FREE   = 2'd1;
    localparam logic [1:0] OP_FORMAT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CHECK,
        ST_WRITE,
        ST_FMT,
        ST_DONE
    } state_t;

    // Bit position of the allocated flag inside a header word.
    function automatic int unsigned hdr_flag(input int unsigned data_w);
        return data_w - 1;
    endfunction

    function automatic int unsigned num_blocks(input int unsigned addr_w,
                                               input int unsigned block_words);
        return (32'd1 << addr_w) / block_words;
    endfunction

    function automatic int unsigned idx_w(input int unsigned addr_w,
                                          input int unsigned block_words);
        return $clog2(num_blocks(addr_w, block_words));
    endfunction

endpackage

// File: rtl/block_allocator_if.sv
// Request/completion bundle between a list module and the block allocator.
interface block_allocator_if #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned BLOCK_WORDS = 32
);
    import block_alloc_pkg::*;

    localparam int unsigned IDX_W = idx_w(ADDR_W, BLOCK_WORDS);

    logic              req;
    logic [1:0]        op;
    logic [ADDR_W-1:0] in_address;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] out_address;
    logic [IDX_W:0]    free_count;

    modport master (
        output req, op, in_address,
        input  busy, done, err, out_address, free_count
    );

    modport slave (
        input  req, op, in_address,
        output busy, done, err, out_address, free_count
    );

endinterface

// File: rtl/block_allocator_next_fit_ptr.sv
// Next-fit search pointer cycling over blocks 1..NUM_BLOCKS-1, plus probe counter.
module next_fit_ptr #(
    parameter int unsigned IDX_W      = 5,
    parameter int unsigned NUM_BLOCKS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_start,
    input  logic             i_advance,
    output logic [IDX_W-1:0] o_ptr,
    output logic [IDX_W-1:0] o_ptr_nx_c,
    output logic             o_exhausted_c
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_cnt;

    // Wrap from the last block straight to 1 so the null block is never probed.
    assign o_ptr_nx_c = (r_ptr == IDX_W'(NUM_BLOCKS - 1)) ? IDX_W'(1) : r_ptr + IDX_W'(1);
    // The current probe is the last one the search may make.
    assign o_exhausted_c = (r_cnt == IDX_W'(NUM_BLOCKS - 2));
    assign o_ptr = r_ptr;

    // Pointer and probe-count registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr <= IDX_W'(1);
            r_cnt <= '0;
        end else begin
            if (i_load) begin
                r_ptr <= IDX_W'(1);
            end else if (i_advance) begin
                r_ptr <= o_ptr_nx_c;
            end
            if (i_start) begin
                r_cnt <= '0;
            end else if (i_advance) begin
                r_cnt <= r_cnt + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/block_allocator.sv
// Next-fit fixed-size block allocator driving a single-port card-list RAM.
module block_allocator #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned BLOCK_WORDS = 32
) (
    input  logic              clock,
    input  logic              reset,
    block_allocator_if.slave  bus,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_clock,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);
    import block_alloc_pkg::*;

    localparam int unsigned NUM_BLOCKS = num_blocks(ADDR_W, BLOCK_WORDS);
    localparam int unsigned IDX_W      = idx_w(ADDR_W, BLOCK_WORDS);
    localparam int unsigned OFF_W      = $clog2(BLOCK_WORDS);
    localparam int unsigned FC_W       = IDX_W + 1;
    localparam int unsigned FLAG       = hdr_flag(DATA_W);
    localparam logic [DATA_W-1:0] FLAG_WORD = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            r_state,  w_state_nx;
    logic              r_busy;
    logic              r_done;
    logic              r_err,    w_err_nx;
    logic [ADDR_W-1:0] r_out_address, w_out_address_nx;
    logic [FC_W-1:0]   r_free_count,  w_free_count_nx;
    logic [ADDR_W-1:0] r_ram_address, w_ram_address_nx;
    logic [DATA_W-1:0] r_ram_data,    w_ram_data_nx;
    logic              r_ram_wren,    w_ram_wren_nx;
    logic [1:0]        r_op,     w_op_nx;
    logic [IDX_W-1:0]  r_fmt_idx, w_fmt_idx_nx;

    logic              w_ptr_load, w_ptr_start, w_ptr_advance;
    logic [IDX_W-1:0]  w_ptr, w_ptr_nx_c;
    logic              w_exhausted_c;
    logic              w_free_bad_c;
    logic              w_unused_q;

    next_fit_ptr #(
        .IDX_W      (IDX_W),
        .NUM_BLOCKS (NUM_BLOCKS)
    ) u_ptr (
        .clock         (clock),
        .reset         (reset),
        .i_load        (w_ptr_load),
        .i_start       (w_ptr_start),
        .i_advance     (w_ptr_advance),
        .o_ptr         (w_ptr),
        .o_ptr_nx_c    (w_ptr_nx_c),
        .o_exhausted_c (w_exhausted_c)
    );

    // Only the header flag of a read word is ever inspected.
    assign w_unused_q   = ^ram_q[DATA_W-2:0];
    assign w_free_bad_c = (bus.in_address[OFF_W-1:0] != '0) || (bus.in_address == '0);

    // Next-state and next-output logic.
    always_comb begin
        w_state_nx       = r_state;
        w_err_nx         = r_err;
        w_out_address_nx = r_out_address;
        w_free_count_nx  = r_free_count;
        w_ram_address_nx = r_ram_address;
        w_ram_data_nx    = '0;
        w_ram_wren_nx    = 1'b0;
        w_op_nx          = r_op;
        w_fmt_idx_nx     = r_fmt_idx;
        w_ptr_load       = 1'b0;
        w_ptr_start      = 1'b0;
        w_ptr_advance    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.req) begin
                    w_op_nx          = bus.op;
                    w_err_nx         = 1'b0;
                    w_out_address_nx = '0;
                    case (bus.op)
                        OP_ALLOC: begin
                            w_state_nx       = ST_READ;
                            w_ram_address_nx = {w_ptr, {OFF_W{1'b0}}};
                            w_ptr_start      = 1'b1;
                        end
                        OP_FREE: begin
                            if (w_free_bad_c) begin
                                w_state_nx = ST_DONE;
                                w_err_nx   = 1'b1;
                            end else begin
                                w_state_nx       = ST_READ;
                                w_ram_address_nx = bus.in_address;
                            end
                        end
                        OP_FORMAT: begin
                            w_state_nx       = ST_FMT;
                            w_ram_address_nx = '0;
                            w_ram_data_nx    = FLAG_WORD;
                            w_ram_wren_nx    = 1'b1;
                            w_fmt_idx_nx     = '0;
                            w_ptr_load       = 1'b1;
                        end
                        default: begin
                            w_state_nx = ST_DONE;
                            w_err_nx   = 1'b1;
                        end
                    endcase
                end
            end
            ST_READ: begin
                w_state_nx = ST_CHECK;
            end
            ST_CHECK: begin
                if (r_op == OP_ALLOC) begin
                    if (!ram_q[FLAG]) begin
                        w_state_nx    = ST_WRITE;
                        w_ram_data_nx = FLAG_WORD;
                        w_ram_wren_nx = 1'b1;
                        w_ptr_advance = 1'b1;
                    end else if (w_exhausted_c) begin
                        // A full lap brings the pointer back to where it started.
                        w_state_nx       = ST_DONE;
                        w_err_nx         = 1'b1;
                        w_out_address_nx = '0;
                        w_ptr_advance    = 1'b1;
                    end else begin
                        w_state_nx       = ST_READ;
                        w_ram_address_nx = {w_ptr_nx_c, {OFF_W{1'b0}}};
                        w_ptr_advance    = 1'b1;
                    end
                end else begin
                    if (!ram_q[FLAG]) begin
                        w_state_nx = ST_DONE;
                        w_err_nx   = 1'b1;
                    end else begin
                        w_state_nx    = ST_WRITE;
                        w_ram_wren_nx = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                w_state_nx = ST_DONE;
                if (r_op == OP_ALLOC) begin
                    w_out_address_nx = r_ram_address;
                    if (r_free_count != '0) begin
                        w_free_count_nx = r_free_count - FC_W'(1);
                    end
                end else if (r_free_count < FC_W'(NUM_BLOCKS - 1)) begin
                    w_free_count_nx = r_free_count + FC_W'(1);
                end
            end
            ST_FMT: begin
                if (r_fmt_idx == IDX_W'(NUM_BLOCKS - 1)) begin
                    w_state_nx      = ST_DONE;
                    w_free_count_nx = FC_W'(NUM_BLOCKS - 1);
                end else begin
                    w_fmt_idx_nx     = r_fmt_idx + IDX_W'(1);
                    w_ram_address_nx = {r_fmt_idx + IDX_W'(1), {OFF_W{1'b0}}};
                    w_ram_wren_nx    = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_out_address <= '0;
            r_free_count  <= '0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_ram_wren    <= 1'b0;
            r_op          <= OP_ALLOC;
            r_fmt_idx     <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_busy        <= (w_state_nx != ST_IDLE);
            r_done        <= (w_state_nx == ST_DONE);
            r_err         <= w_err_nx;
            r_out_address <= w_out_address_nx;
            r_free_count  <= w_free_count_nx;
            r_ram_address <= w_ram_address_nx;
            r_ram_data    <= w_ram_data_nx;
            r_ram_wren    <= w_ram_wren_nx;
            r_op          <= w_op_nx;
            r_fmt_idx     <= w_fmt_idx_nx;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.out_address = r_out_address;
    assign bus.free_count  = r_free_count;
    assign ram_address     = r_ram_address;
    assign ram_data        = r_ram_data;
    assign ram_wren        = r_ram_wren;
    assign ram_clock       = clock;

endmodule

// File: tb/tb_block_allocator.sv
// Randomised check of block_allocator against a free-list reference model.
module tb_block_allocator;
    import block_alloc_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int BW     = 32;
    localparam int NB     = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_clock;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    block_allocator_if #(.ADDR_W(ADDR_W), .BLOCK_WORDS(BW)) bus ();

    block_allocator #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BLOCK_WORDS (BW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .ram_address (ram_address),
        .ram_clock   (ram_clock),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    always #5 clock = ~clock;

    // Single-port RAM fixture with one-cycle read latency; scrub fills it with junk.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic              scrub = 1'b0;
    logic [ADDR_W-1:0] scrub_addr = '0;
    always @(posedge ram_clock) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        else if (scrub) mem[scrub_addr] <= $urandom;
        ram_q <= mem[ram_address];
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: which blocks are taken, next-fit start, free count.
    bit [NB-1:0] m_used;
    int          m_ptr;
    int          m_fc;

    task automatic model_format();
        m_used    = '0;
        m_used[0] = 1'b1;
        m_fc      = NB - 1;
        m_ptr     = 1;
    endtask

    // Issue one request, wait for done, return latency, err, address and write count.
    task automatic do_op(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                         output int lat, output logic e, output logic [ADDR_W-1:0] oa,
                         output int nwr);
        @(negedge clock);
        bus.req = 1'b1; bus.op = op; bus.in_address = addr;
        @(posedge clock); #1;
        bus.req = 1'b0;
        lat = 0; nwr = 0;
        for (int c = 1; c <= 200; c++) begin
            if (ram_wren) nwr++;
            if (bus.done) begin
                lat = c;
                break;
            end
            @(posedge clock); #1;
        end
        e  = bus.err;
        oa = bus.out_address;
        chk("busy_at_done", 64'(bus.busy), 64'(lat != 0));
        @(posedge clock); #1;
    endtask

    task automatic check_op(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                            output int lat, output logic e, output logic [ADDR_W-1:0] oa);
        int x_lat, x_wr, nwr, idx, p, found, k;
        logic x_err;
        logic [ADDR_W-1:0] x_oa;
        x_lat = 0; x_wr = 0; x_err = 1'b0; x_oa = '0; k = 0; found = -1;
        case (op)
            OP_ALLOC: begin
                p = m_ptr;
                for (int i = 0; i < NB - 1; i++) begin
                    if (!m_used[p]) begin
                        found = p; k = i;
                        break;
                    end
                    p = (p == NB - 1) ? 1 : p + 1;
                end
                if (found >= 0) begin
                    x_lat = 2 * k + 4; x_wr = 1; x_oa = ADDR_W'(found * BW);
                    m_used[found] = 1'b1;
                    if (m_fc > 0) m_fc--;
                    m_ptr = (found == NB - 1) ? 1 : found + 1;
                end else begin
                    x_lat = 2 * (NB - 1) + 1; x_err = 1'b1;
                end
            end
            OP_FREE: begin
                idx = int'(addr) / BW;
                if ((int'(addr) % BW) != 0 || addr == '0) begin
                    x_lat = 1; x_err = 1'b1;
                end else if (!m_used[idx]) begin
                    x_lat = 3; x_err = 1'b1;
                end else begin
                    x_lat = 4; x_wr = 1;
                    m_used[idx] = 1'b0;
                    if (m_fc < NB - 1) m_fc++;
                end
            end
            OP_FORMAT: begin
                model_format();
                x_lat = NB + 1; x_wr = NB;
            end
            default: begin
                x_lat = 1; x_err = 1'b1;
            end
        endcase
        do_op(op, addr, lat, e, oa, nwr);
        chk($sformatf("op%0d_lat", op), 64'(lat), 64'(x_lat));
        chk($sformatf("op%0d_err", op), 64'(e), 64'(x_err));
        chk($sformatf("op%0d_wren_cycles", op), 64'(nwr), 64'(x_wr));
        if (op == OP_ALLOC) chk("alloc_addr", 64'(oa), 64'(x_oa));
        chk($sformatf("op%0d_free_count", op), 64'(bus.free_count), 64'(m_fc));
    endtask

    task automatic check_headers(input string tag);
        logic [NB-1:0] flags;
        int odd;
        odd = 0;
        for (int b = 0; b < NB; b++) begin
            flags[b] = mem[b * BW][DATA_W-1];
            if (mem[b * BW] != 32'h8000_0000 && mem[b * BW] != 32'h0) odd++;
        end
        chk({tag, "_hdr_flags"}, 64'(flags), 64'(m_used));
        chk({tag, "_hdr_words"}, 64'(odd), 64'd0);
    endtask

    task automatic random_ops(input int count);
        int r, idx, lat;
        logic e;
        logic [1:0] op;
        logic [ADDR_W-1:0] addr, oa;
        for (int n = 0; n < count; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45)      op = OP_ALLOC;
            else if (r < 88) op = OP_FREE;
            else if (r < 94) op = OP_FORMAT;
            else             op = 2'd3;
            idx  = int'($urandom_range(0, NB - 1));
            addr = ADDR_W'(idx * BW);
            if ($urandom_range(0, 4) == 0) addr = addr + ADDR_W'($urandom_range(1, BW - 1));
            check_op(op, addr, lat, e, oa);
            if (n % 10 == 9) check_headers("rnd");
        end
    endtask

    initial begin
        int lat, ndone, first;
        logic e;
        logic [ADDR_W-1:0] oa;

        bus.req = 1'b0; bus.op = OP_ALLOC; bus.in_address = '0;
        m_used = '0; m_ptr = 1; m_fc = 0;

        // Fill the RAM with junk while reset is held.
        scrub = 1'b1;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            scrub_addr = ADDR_W'(i);
            @(posedge clock); #1;
        end
        scrub = 1'b0;

        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_out_address", 64'(bus.out_address), 64'd0);
        chk("rst_free_count", 64'(bus.free_count), 64'd0);
        chk("rst_ram_wren", 64'(ram_wren), 64'd0);
        chk("rst_ram_address", 64'(ram_address), 64'd0);
        chk("rst_ram_data", 64'(ram_data), 64'd0);
        @(negedge clock); reset = 1'b0;

        // Format and a short directed alloc/free sequence.
        check_op(OP_FORMAT, '0, lat, e, oa);
        chk("fmt_lat", 64'(lat), 64'd33);
        chk("fmt_free_count", 64'(bus.free_count), 64'd31);
        chk("fmt_hdr0", 64'(mem[0]), 64'h8000_0000);
        check_headers("fmt");
        check_op(OP_ALLOC, '0, lat, e, oa);
        chk("alloc1_lat", 64'(lat), 64'd4);
        chk("alloc1_addr", 64'(oa), 64'd32);
        check_op(OP_ALLOC, '0, lat, e, oa);
        chk("alloc2_addr", 64'(oa), 64'd64);
        chk("alloc2_free_count", 64'(bus.free_count), 64'd29);
        chk("alloc_hdr32", 64'(mem[32]), 64'h8000_0000);
        chk("alloc_hdr64", 64'(mem[64]), 64'h8000_0000);
        check_op(OP_FREE, 10'd32, lat, e, oa);
        chk("free32_lat", 64'(lat), 64'd4);
        chk("free32_hdr", 64'(mem[32]), 64'd0);
        chk("free32_free_count", 64'(bus.free_count), 64'd30);
        check_op(OP_FREE, 10'd32, lat, e, oa);
        chk("double_free_err", 64'(e), 64'd1);
        check_op(OP_FREE, 10'd33, lat, e, oa);
        chk("unaligned_free_lat", 64'(lat), 64'd1);

        random_ops(150);

        // Fill the pool, fail one alloc, then free and wrap.
        check_op(OP_FORMAT, '0, lat, e, oa);
        for (int i = 1; i < NB; i++) begin
            check_op(OP_ALLOC, '0, lat, e, oa);
            chk("fill_addr", 64'(oa), 64'(i * BW));
        end
        chk("full_free_count", 64'(bus.free_count), 64'd0);
        check_op(OP_ALLOC, '0, lat, e, oa);
        chk("full_alloc_lat", 64'(lat), 64'd63);
        chk("full_alloc_err", 64'(e), 64'd1);
        chk("full_alloc_addr", 64'(oa), 64'd0);
        check_op(OP_FREE, 10'd96, lat, e, oa);
        check_op(OP_ALLOC, '0, lat, e, oa);
        chk("wrap_lat", 64'(lat), 64'd8);
        chk("wrap_addr", 64'(oa), 64'd96);
        check_headers("full");

        // Asynchronous reset in the middle of a format.
        @(negedge clock);
        bus.req = 1'b1; bus.op = OP_FORMAT; bus.in_address = '0;
        @(posedge clock); #1;
        bus.req = 1'b0;
        repeat (9) @(posedge clock);
        #2;
        chk("fmt10_wren", 64'(ram_wren), 64'd1);
        chk("fmt10_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst_wren", 64'(ram_wren), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        @(negedge clock); reset = 1'b0;
        m_ptr = 1; m_fc = 0;
        chk("midrst_free_count", 64'(bus.free_count), 64'd0);

        check_op(2'd3, '0, lat, e, oa);
        chk("reserved_lat", 64'(lat), 64'd1);

        // A request held through the whole operation is taken only once.
        @(negedge clock);
        bus.req = 1'b1; bus.op = OP_FORMAT; bus.in_address = '0;
        @(posedge clock); #1;
        ndone = 0; first = 0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.done) begin
                ndone++;
                if (first == 0) first = c;
            end
            if (c == 34) bus.req = 1'b0;
            @(posedge clock); #1;
        end
        model_format();
        chk("held_req_dones", 64'(ndone), 64'd1);
        chk("held_req_done_cycle", 64'(first), 64'd33);
        chk("held_req_idle", 64'(bus.busy), 64'd0);
        check_headers("held");

        random_ops(40);
        check_headers("final");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
